// File: rtl/fir_out_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fir_out_stage
//  Description : FIR output stage: decimation, round-half-up, shift, saturate
//                and a show-ahead output FIFO with drop/saturation counters.
//  Revision    : 1.0  initial release
// ============================================================================
module fir_out_stage #(
    parameter int SHIFT      = 23,
    parameter int OUT_W      = 24,
    parameter int DECIM      = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [47:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [15:0]      sat_count,
    output logic [15:0]      drop_count,
    output logic             overrun
);

    localparam int                 c_PH_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int                 c_AW      = $clog2(FIFO_DEPTH);
    localparam logic [c_PH_W-1:0]  c_PH_LAST = c_PH_W'(DECIM - 1);
    localparam logic signed [48:0] c_RND     = 49'sd1 <<< (SHIFT - 1);
    localparam logic signed [48:0] c_MAX     = (49'sd1 <<< (OUT_W - 1)) - 49'sd1;
    localparam logic signed [48:0] c_MIN     = -(49'sd1 <<< (OUT_W - 1));
    localparam logic [c_AW:0]      c_FULL    = (c_AW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Decimation phase
    // ------------------------------------------------------------------
    logic [c_PH_W-1:0] r_phase;
    logic              w_keep;

    assign w_keep = in_valid && (r_phase == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= '0;
        end else if (in_valid) begin
            r_phase <= (r_phase == c_PH_LAST) ? '0 : r_phase + c_PH_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: add the rounding constant with one guard bit so it never wraps
    // ------------------------------------------------------------------
    logic signed [48:0] w_s1_sum;
    logic signed [48:0] r_s1_sum;
    logic               r_s1_valid;

    assign w_s1_sum = $signed({in_data[47], in_data}) + c_RND;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
        end else begin
            r_s1_valid <= w_keep;
            if (w_keep) begin
                r_s1_sum <= w_s1_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: arithmetic shift and clamp to the output range
    // ------------------------------------------------------------------
    logic signed [48:0] w_shifted;
    logic [OUT_W-1:0]   w_clamped;
    logic               w_sat;
    logic [OUT_W-1:0]   r_s2_data;
    logic               r_s2_sat;
    logic               r_s2_valid;

    assign w_shifted = r_s1_sum >>> SHIFT;

    always_comb begin
        w_sat     = 1'b0;
        w_clamped = w_shifted[OUT_W-1:0];
        if (w_shifted > c_MAX) begin
            w_sat     = 1'b1;
            w_clamped = c_MAX[OUT_W-1:0];
        end else if (w_shifted < c_MIN) begin
            w_sat     = 1'b1;
            w_clamped = c_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_sat   <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sat  <= w_sat;
                r_s2_data <= w_clamped;
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead output FIFO
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
    assign w_full = (r_count == c_FULL);
    assign w_pop  = out_valid && out_ready;
    assign w_drop = r_s2_valid && w_full && !w_pop;
    assign w_push = r_s2_valid && !w_drop;

    assign out_valid = !reset && (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign overrun   = !reset && w_drop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_s2_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    logic [15:0] r_sat_count;
    logic [15:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sat_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (r_s2_valid && r_s2_sat && (r_sat_count != 16'hFFFF)) begin
                r_sat_count <= r_sat_count + 16'd1;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign sat_count  = r_sat_count;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_fir_out_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_out_stage
//  Description : Self-checking bench for fir_out_stage (DECIM=1 and DECIM=3).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fir_out_stage;

    localparam int SHIFT = 23;
    localparam int OUT_W = 24;
    localparam int FD    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [47:0]      in_data;
    logic             out_ready;
    logic [1:0]       ov;
    logic [1:0]       orun;
    logic [OUT_W-1:0] od [2];
    logic [15:0]      sc [2];
    logic [15:0]      dc [2];

    always #5 clk = ~clk;

    fir_out_stage #(.SHIFT(SHIFT), .OUT_W(OUT_W), .DECIM(1), .FIFO_DEPTH(FD)) u_d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .sat_count(sc[0]), .drop_count(dc[0]), .overrun(orun[0])
    );

    fir_out_stage #(.SHIFT(SHIFT), .OUT_W(OUT_W), .DECIM(3), .FIFO_DEPTH(FD)) u_d3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .sat_count(sc[1]), .drop_count(dc[1]), .overrun(orun[1])
    );

    int n_chk  = 0;
    int n_pass = 0;
    int orun_seen = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference model: per-instance two-cycle delay line and an output queue
    int     decim_of [2] = '{1, 3};
    longint mq [2][$];
    bit     pv [2][2];
    longint pd [2][2];
    bit     ps [2][2];
    int     ph [2];
    int     msat [2];
    int     mdrop [2];

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            for (int j = 0; j < 2; j++) begin
                pv[k][j] = 0; pd[k][j] = 0; ps[k][j] = 0;
            end
            ph[k] = 0; msat[k] = 0; mdrop[k] = 0;
        end
    endfunction

    function automatic void ref_sample(input logic [47:0] x, output longint v, output bit s);
        longint t, hi, lo;
        t  = longint'($signed(x));
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_W - 1));
        t  = (t + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        s  = 0;
        if (t > hi) begin v = hi; s = 1; end
        else if (t < lo) begin v = lo; s = 1; end
        else v = t;
    endfunction

    function automatic logic [47:0] rand_data();
        logic [63:0] r;
        longint      s;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: s = longint'(r);
            1: s = longint'(r) >>> 24;
            2: s = (longint'($urandom_range(0, 2000)) - 1000) * 64'sd8388608
                   + 64'sd4194304 + longint'($urandom_range(0, 2)) - 1;
            default: s = (r[0] ? 64'sd70368744177664 : -64'sd70368744177664)
                   + longint'($urandom_range(0, 255)) - 128;
        endcase
        return s[47:0];
    endfunction

    task automatic step(input bit v, input logic [47:0] d, input bit r);
        bit     pop  [2];
        bit     drop [2];
        bit     ev;
        longint sv;
        bit     ss;
        @(negedge clk);
        reset = 0; in_valid = v; in_data = d; out_ready = r;
        #1;
        for (int k = 0; k < 2; k++) begin
            ev = (mq[k].size() > 0);
            chk($sformatf("u%0d out_valid", k), longint'(ov[k]), longint'(ev));
            if (ev) chk($sformatf("u%0d out_data", k), longint'($signed(od[k])), mq[k][0]);
            pop[k]  = ev && r;
            drop[k] = pv[k][1] && (mq[k].size() == FD) && !pop[k];
            chk($sformatf("u%0d overrun", k), longint'(orun[k]), longint'(drop[k]));
            chk($sformatf("u%0d sat_count", k), longint'(sc[k]), longint'(msat[k]));
            chk($sformatf("u%0d drop_count", k), longint'(dc[k]), longint'(mdrop[k]));
        end
        if (orun[0]) orun_seen++;
        @(posedge clk);
        ref_sample(d, sv, ss);
        for (int k = 0; k < 2; k++) begin
            if (pop[k]) void'(mq[k].pop_front());
            if (pv[k][1]) begin
                if (ps[k][1] && msat[k] < 65535) msat[k]++;
                if (drop[k]) begin
                    if (mdrop[k] < 65535) mdrop[k]++;
                end else begin
                    mq[k].push_back(pd[k][1]);
                end
            end
            pv[k][1] = pv[k][0]; pd[k][1] = pd[k][0]; ps[k][1] = ps[k][0];
            pv[k][0] = v && (ph[k] == 0);
            pd[k][0] = sv; ps[k][0] = ss;
            if (v) ph[k] = (ph[k] + 1) % decim_of[k];
        end
    endtask

    task automatic do_reset(input int n, input bit v);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1; in_valid = v; in_data = rand_data(); out_ready = 1'($urandom_range(0, 1));
            #1;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d rst out_valid", k), longint'(ov[k]), 0);
                chk($sformatf("u%0d rst overrun", k), longint'(orun[k]), 0);
                if (i > 0) begin
                    chk($sformatf("u%0d rst sat_count", k), longint'(sc[k]), 0);
                    chk($sformatf("u%0d rst drop_count", k), longint'(dc[k]), 0);
                    chk($sformatf("u%0d rst out_data", k), longint'(od[k]), 0);
                end
            end
            @(posedge clk);
            model_clear();
        end
    endtask

    function automatic logic [47:0] unit(input int k);
        longint t;
        t = longint'(k) <<< 23;
        return t[47:0];
    endfunction

    logic [47:0] rnd_in  [4] = '{48'h000000800000, 48'h000000400000, 48'hFFFFFFC00000, 48'hFFFFFFBFFFFF};
    longint      rnd_exp [4] = '{1, 1, 0, -1};
    int          dec_exp [3] = '{1, 4, 7};

    initial begin
        reset = 1; in_valid = 0; in_data = '0; out_ready = 0;
        model_clear();
        do_reset(3, 1);

        // Rounding, one sample at a time
        for (int i = 0; i < 4; i++) begin
            step(1, rnd_in[i], 1); step(0, '0, 1); step(0, '0, 1);
            #1;
            chk("rnd out_valid", longint'(ov[0]), 1);
            chk("rnd out_data", longint'($signed(od[0])), rnd_exp[i]);
        end
        chk("rnd sat_count", longint'(sc[0]), 0);

        // Saturation at both rails
        do_reset(1, 0);
        step(1, 48'h7FFFFFFFFFFF, 1); step(0, '0, 1); step(0, '0, 1);
        #1; chk("sat pos", longint'($signed(od[0])), 8388607);
        step(1, 48'h800000000000, 1); step(0, '0, 1); step(0, '0, 1);
        #1; chk("sat neg", longint'($signed(od[0])), -8388608);
        chk("sat count", longint'(sc[0]), 2);

        // Backpressure with overflow
        do_reset(1, 0);
        orun_seen = 0;
        for (int k = 1; k <= 6; k++) step(1, unit(k), 0);
        step(0, '0, 0); step(0, '0, 0);
        #1;
        chk("bp drop_count", longint'(dc[0]), 2);
        chk("bp overrun pulses", longint'(orun_seen), 2);
        for (int k = 1; k <= 4; k++) begin
            chk("bp order", longint'($signed(od[0])), longint'(k));
            step(0, '0, 1);
            #1;
        end
        chk("bp drained", longint'(ov[0]), 0);

        // Write and pop in the same cycle on a full FIFO
        do_reset(1, 0);
        for (int k = 1; k <= 5; k++) step(1, unit(k), 0);
        step(0, '0, 0);
        orun_seen = 0;
        step(0, '0, 1);
        #1;
        chk("sim overrun", longint'(orun_seen), 0);
        chk("sim drop_count", longint'(dc[0]), 0);
        for (int k = 2; k <= 5; k++) begin
            chk("sim order", longint'($signed(od[0])), longint'(k));
            step(0, '0, 1);
            #1;
        end
        chk("sim drained", longint'(ov[0]), 0);

        // Decimation by 3
        do_reset(1, 0);
        for (int k = 1; k <= 9; k++) step(1, unit(k), 0);
        step(0, '0, 0); step(0, '0, 0);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("dec valid", longint'(ov[1]), 1);
            chk("dec data", longint'($signed(od[1])), longint'(dec_exp[i]));
            step(0, '0, 1);
            #1;
        end
        chk("dec drained", longint'(ov[1]), 0);

        // Reset mid-stream with buffered samples and in_valid held high
        do_reset(1, 0);
        for (int k = 0; k < 4; k++) step(1, 48'h7FFFFFFFFFFF, 0);
        step(0, '0, 0); step(0, '0, 0);
        do_reset(1, 1);
        #1;
        chk("mid rst valid0", longint'(ov[0]), 0);
        chk("mid rst valid1", longint'(ov[1]), 0);
        chk("mid rst sat0", longint'(sc[0]), 0);
        chk("mid rst drop0", longint'(dc[0]), 0);
        do_reset(1, 1);
        step(1, unit(1), 1); step(1, unit(2), 1); step(1, unit(3), 1);
        #1;
        chk("restart valid", longint'(ov[1]), 1);
        chk("restart data", longint'($signed(od[1])), 1);

        // Sustained throughput
        do_reset(1, 0);
        for (int i = 0; i < 100; i++) step(1, rand_data(), 1);
        #1;
        chk("burst drop_count", longint'(dc[0]), 0);

        // Randomized traffic
        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(0, 199) == 0)
                do_reset($urandom_range(1, 3), 1'($urandom_range(0, 1)));
            else
                step($urandom_range(0, 9) < 7, rand_data(), $urandom_range(0, 9) < 6);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
